// File: rtl/instr_loader.sv
// Instruction ROM loader: takes a load command (base address, count), gathers four stream
// words per instruction, packs them into one wide instruction and issues a single-cycle ROM
// write per instruction. The core is held off while a load is in progress.
module instr_loader #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [AddrWidth-1:0]     baseAddr,
    input  logic [AddrWidth:0]       numInstr,
    input  logic                     sWordValid,
    input  logic [DataWidth-1:0]     sWordData,
    output logic                     sWordReady,
    output logic [AddrWidth-1:0]     writeAddr,
    output logic [DataWidth*4-1:0]   writeData,
    output logic                     writeEn,
    output logic                     busy,
    output logic                     coreHold,
    output logic                     done,
    input  logic                     abort
);

    localparam int unsigned InstrWidth = DataWidth * 4;

    // Largest count a single command may load: one full pass over the ROM.
    localparam logic [AddrWidth:0]   MaxCount = {1'b1, {AddrWidth{1'b0}}};
    localparam logic [AddrWidth:0]   CountOne = {{AddrWidth{1'b0}}, 1'b1};
    localparam logic [AddrWidth-1:0] AddrOne  = {{(AddrWidth-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StWrite,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              word_idx_q, word_idx_d;
    logic [AddrWidth:0]      remaining_q, remaining_d;
    logic [AddrWidth-1:0]    cur_addr_q, cur_addr_d;
    logic [InstrWidth-1:0]   asm_q, asm_d;

    logic [AddrWidth:0]      clamped_count;
    logic                    handshake;

    assign clamped_count = (numInstr > MaxCount) ? MaxCount : numInstr;
    assign handshake     = sWordValid & sWordReady;

    // State and datapath registers; async reset clears everything so all outputs drop at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            word_idx_q  <= 2'd0;
            remaining_q <= '0;
            cur_addr_q  <= '0;
            asm_q       <= '0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            remaining_q <= remaining_d;
            cur_addr_q  <= cur_addr_d;
            asm_q       <= asm_d;
        end
    end

    // Next-state and Moore outputs; every output depends only on registered state.
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        remaining_d = remaining_q;
        cur_addr_d  = cur_addr_q;
        asm_d       = asm_q;
        sWordReady  = 1'b0;
        writeEn     = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // start takes priority over abort here; abort is a no-op in idle.
                if (start) begin
                    cur_addr_d  = baseAddr;
                    remaining_d = clamped_count;
                    word_idx_d  = 2'd0;
                    asm_d       = '0;
                    state_d     = (clamped_count == '0) ? StDone : StRecv;
                end
            end

            StRecv: begin
                sWordReady = 1'b1;
                if (abort) begin
                    // Drop the partial instruction, including any word offered this cycle.
                    word_idx_d = 2'd0;
                    asm_d      = '0;
                    state_d    = StIdle;
                end else if (handshake) begin
                    asm_d[word_idx_q*DataWidth +: DataWidth] = sWordData;
                    word_idx_d = word_idx_q + 2'd1;
                    if (word_idx_q == 2'd3) begin
                        state_d = StWrite;
                    end
                end
            end

            StWrite: begin
                // The write in this cycle always completes, even under abort.
                writeEn     = 1'b1;
                cur_addr_d  = cur_addr_q + AddrOne;
                remaining_d = remaining_q - CountOne;
                if (abort) begin
                    state_d = StIdle;
                end else if (remaining_q == CountOne) begin
                    state_d = StDone;
                end else begin
                    state_d = StRecv;
                end
            end

            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign writeAddr = cur_addr_q;
    assign writeData = asm_q;
    assign busy      = (state_q != StIdle);
    assign coreHold  = busy;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected ROM writes are queued as words are sent and
// compared as writeEn is observed.
module tb_instr_loader;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;

    logic              clk;
    logic              rst;
    logic              start;
    logic [AW-1:0]     baseAddr;
    logic [AW:0]       numInstr;
    logic              sWordValid;
    logic [DW-1:0]     sWordData;
    logic              sWordReady;
    logic [AW-1:0]     writeAddr;
    logic [DW*4-1:0]   writeData;
    logic              writeEn;
    logic              busy;
    logic              coreHold;
    logic              done;
    logic              abort;

    instr_loader #(
        .DataWidth(DW),
        .AddrWidth(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .baseAddr  (baseAddr),
        .numInstr  (numInstr),
        .sWordValid(sWordValid),
        .sWordData (sWordData),
        .sWordReady(sWordReady),
        .writeAddr (writeAddr),
        .writeData (writeData),
        .writeEn   (writeEn),
        .busy      (busy),
        .coreHold  (coreHold),
        .done      (done),
        .abort     (abort)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_writes = 0;
    int n_done = 0;

    logic [AW-1:0]   exp_addr_q[$];
    logic [DW*4-1:0] exp_data_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DW*4-1:0] got,
                         input logic [DW*4-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: every observed write is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (writeEn) begin
                n_writes++;
                check("rdy_in_wr", {127'd0, sWordReady}, '0);
                if (exp_addr_q.size() == 0) begin
                    check("unexp_wr", 128'd1, 128'd0);
                end else begin
                    check("wr_addr", {118'd0, writeAddr}, {118'd0, exp_addr_q.pop_front()});
                    check("wr_data", writeData, exp_data_q.pop_front());
                end
            end
            if (done) n_done++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] n);
        start    = 1'b1;
        baseAddr = base;
        numInstr = n;
        idle(1);
        start    = 1'b0;
    endtask

    // Offer one word and hold it until accepted; returns one tick after the handshake edge.
    task automatic send_word(input logic [DW-1:0] w);
        int t;
        t = 0;
        sWordValid = 1'b1;
        sWordData  = w;
        forever begin
            @(negedge clk);
            if (sWordReady) break;
            t++;
            if (t > 100) begin
                check("rdy_timeout", 128'd0, 128'd1);
                break;
            end
        end
        idle(1);
        sWordValid = 1'b0;
    endtask

    task automatic send_instr(input logic [AW-1:0] addr, input logic [DW-1:0] w0,
                              input logic [DW-1:0] w1, input logic [DW-1:0] w2,
                              input logic [DW-1:0] w3, input int gap);
        exp_addr_q.push_back(addr);
        exp_data_q.push_back({w3, w2, w1, w0});
        send_word(w0); idle(gap);
        send_word(w1); idle(gap);
        send_word(w2); idle(gap);
        send_word(w3); idle(gap);
    endtask

    task automatic wait_done(input int limit);
        int t;
        t = 0;
        while (t < limit) begin
            @(negedge clk);
            if (done) break;
            t++;
        end
        if (t >= limit) check("done_timeout", 128'd0, 128'd1);
        idle(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        int d0;

        rst        = 1'b1;
        start      = 1'b0;
        baseAddr   = '0;
        numInstr   = '0;
        sWordValid = 1'b0;
        sWordData  = '0;
        abort      = 1'b0;
        #1;
        check("rst_busy", {127'd0, busy}, '0);
        check("rst_wen", {127'd0, writeEn}, '0);
        check("rst_rdy", {127'd0, sWordReady}, '0);
        check("rst_data", writeData, '0);
        idle(2);
        rst = 1'b0;
        idle(1);

        // Single load with exact timing.
        w0 = n_writes; d0 = n_done;
        do_start(10'd5, 11'd1);
        check("t1_busy", {127'd0, busy}, 128'd1);
        check("t1_hold", {127'd0, coreHold}, 128'd1);
        exp_addr_q.push_back(10'd5);
        exp_data_q.push_back(128'h44444444_33333333_22222222_11111111);
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        send_word(32'h44444444);
        check("t1_lat_wen", {127'd0, writeEn}, 128'd1);
        idle(1);
        check("t1_done", {127'd0, done}, 128'd1);
        check("t1_busy_done", {127'd0, busy}, 128'd1);
        check("t1_wen_off", {127'd0, writeEn}, '0);
        idle(1);
        check("t1_busy_off", {127'd0, busy}, '0);
        check("t1_hold_off", {127'd0, coreHold}, '0);
        check("t1_done_off", {127'd0, done}, '0);
        check("t1_nwr", 128'(n_writes - w0), 128'd1);
        check("t1_ndone", 128'(n_done - d0), 128'd1);

        // Address wrap with backpressure (valid every other cycle).
        w0 = n_writes;
        do_start(10'd1022, 11'd3);
        send_instr(10'd1022, 32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 1);
        send_instr(10'd1023, 32'hB0B0B0B0, 32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3, 1);
        send_instr(10'd0,    32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3, 1);
        wait_done(20);
        check("t2_nwr", 128'(n_writes - w0), 128'd3);
        check("t2_sb_empty", 128'(exp_addr_q.size()), '0);

        // Zero count.
        w0 = n_writes;
        do_start(10'd9, 11'd0);
        check("t3_done", {127'd0, done}, 128'd1);
        check("t3_rdy", {127'd0, sWordReady}, '0);
        idle(1);
        check("t3_busy_off", {127'd0, busy}, '0);
        check("t3_nwr", 128'(n_writes - w0), '0);

        // Abort after six words.
        w0 = n_writes; d0 = n_done;
        do_start(10'd100, 11'd2);
        send_instr(10'd100, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 0);
        send_word(32'hDEADBEEF);
        send_word(32'hCAFEF00D);
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        check("t4_idle", {127'd0, busy}, '0);
        check("t4_rdy", {127'd0, sWordReady}, '0);
        idle(2);
        check("t4_nwr", 128'(n_writes - w0), 128'd1);
        check("t4_ndone", 128'(n_done - d0), '0);
        do_start(10'd200, 11'd1);
        send_instr(10'd200, 32'h51515151, 32'h52525252, 32'h53535353, 32'h54545454, 0);
        wait_done(10);
        check("t4_sb_empty", 128'(exp_addr_q.size()), '0);

        // Asynchronous reset mid-receive.
        d0 = n_done;
        do_start(10'd300, 11'd1);
        send_word(32'h77777777);
        send_word(32'h88888888);
        #2;
        rst = 1'b1;
        #1;
        check("t5_busy", {127'd0, busy}, '0);
        check("t5_hold", {127'd0, coreHold}, '0);
        check("t5_rdy", {127'd0, sWordReady}, '0);
        check("t5_addr", {118'd0, writeAddr}, '0);
        check("t5_data", writeData, '0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        check("t5_ndone", 128'(n_done - d0), '0);
        do_start(10'd7, 11'd1);
        send_instr(10'd7, 32'h90909090, 32'h91919191, 32'h92929292, 32'h93939393, 0);
        wait_done(10);

        // Start while busy is ignored.
        w0 = n_writes;
        do_start(10'd50, 11'd1);
        exp_addr_q.push_back(10'd50);
        exp_data_q.push_back(128'h0000000D_0000000C_0000000B_0000000A);
        send_word(32'h0000000A);
        send_word(32'h0000000B);
        do_start(10'd60, 11'd5);
        send_word(32'h0000000C);
        send_word(32'h0000000D);
        wait_done(10);
        idle(3);
        check("t6_nwr", 128'(n_writes - w0), 128'd1);
        check("t6_busy_off", {127'd0, busy}, '0);

        // Count above ROM depth is clamped to 1024 writes.
        w0 = n_writes; d0 = n_done;
        do_start(10'd0, 11'd1025);
        for (int i = 0; i < 1024; i++) begin
            send_instr(i[AW-1:0], $urandom, $urandom, $urandom, $urandom, 0);
        end
        wait_done(10);
        idle(5);
        check("t7_nwr", 128'(n_writes - w0), 128'd1024);
        check("t7_ndone", 128'(n_done - d0), 128'd1);
        check("t7_busy_off", {127'd0, busy}, '0);
        check("t7_sb_empty", 128'(exp_addr_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer-side companion to the instruction ROM's write port in the PE_SoC build.
- Accepts a load command with base address and instruction count, then receives 32-bit words over a valid/ready stream.
- Packs every four words into one 128-bit instruction and issues a single-cycle ROM write per instruction.
- Holds the processing core off (coreHold) for the duration of the load.

Parameters:
DataWidth, 32, width of one stream word; instruction width is DataWidth*4
AddrWidth, 10, ROM address width; ROM depth is 2**AddrWidth

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  load command strobe; sampled only in IDLE
baseAddr  input  AddrWidth  first ROM address to write; latched on accepted start
numInstr  input  AddrWidth+1  instructions to load; latched on accepted start
sWordValid  input  1  stream word valid
sWordData  input  DataWidth  stream word
sWordReady  output  1  loader can accept a word
writeAddr  output  AddrWidth  ROM write address
writeData  output  DataWidth*4  ROM write data
writeEn  output  1  ROM write strobe
busy  output  1  load in progress (state != IDLE)
coreHold  output  1  stall request to core; equals busy
done  output  1  one-cycle pulse when the load completes normally
abort  input  1  cancel an in-progress load

Behaviour:
- Reset (async, any state): state=IDLE; wordIdx=0; remaining=0; curAddr=0; assembly register=0. All outputs are 0.
- States are IDLE, RECV, WRITE and DONE.
- IDLE:
  - sWordReady=0.
  - start=1 latches curAddr=baseAddr and remaining=min(numInstr, 2**AddrWidth).
  - If the latched count is 0, next state is DONE; otherwise next state is RECV.
  - start in any other state is ignored.
- RECV:
  - sWordReady=1.
  - On a handshake (sWordValid & sWordReady), the word goes into lane wordIdx, bits [DataWidth*(k+1)-1 : DataWidth*k] for k=wordIdx. The first word received is the least-significant lane.
  - wordIdx increments on each handshake. The handshake at wordIdx=3 wraps wordIdx to 0 and moves to WRITE.
  - With no valid, the loader waits indefinitely with no timeout.
- WRITE:
  - sWordReady=0.
  - writeEn=1 for exactly this one cycle, with writeAddr=curAddr and writeData=assembly register.
  - Next cycle: curAddr=curAddr+1, wrapping modulo 2**AddrWidth (1023 -> 0), and remaining decrements.
  - If remaining was 1, next state is DONE; otherwise RECV.
- DONE: done=1 for one cycle, then IDLE.
- Timing:
  - Latency from the 4th word handshake to writeEn is 1 cycle.
  - Peak throughput is 1 instruction per 5 cycles.
  - From the last write to done is 1 cycle.
- Outputs when idle: writeEn=0 outside WRITE. writeAddr and writeData are don't-care when writeEn=0 but must not glitch writeEn.
- abort:
  - abort=1 in RECV or DONE sends the loader to IDLE next cycle. The partial assembly is discarded and wordIdx clears to 0.
  - No done pulse is produced in RECV; a done already being driven in DONE completes.
  - abort in WRITE does not cancel that cycle's write; the loader then goes to IDLE.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: start wins.
- Reset mid-load: the ROM keeps whatever writes have already completed. The partial instruction is lost. No done pulse.
- Capacity: a count above 2**AddrWidth is clamped, so at most 1024 writes are issued per command.

Test Plan:
- Single load: start with baseAddr=5, numInstr=1; words 0x11111111, 0x22222222, 0x33333333, 0x44444444 with valid held high -> one writeEn with writeAddr=5 and writeData=0x44444444_33333333_22222222_11111111, one cycle after the 4th handshake; done pulses next cycle; busy and coreHold are 1 from the cycle after start until the cycle after done.
- Wrap and backpressure: baseAddr=1022, numInstr=3, valid toggled every other cycle -> writes to 1022, 1023 and 0 in order with correct data; sWordReady=0 during each WRITE cycle; no word is dropped or duplicated.
- Zero count: numInstr=0 -> no writeEn, no sWordReady; done pulses 1 cycle after start.
- Abort: numInstr=2, abort asserted after 6 words -> exactly one write (addr=base); no done; idle next cycle. A following start with numInstr=1 and 4 new words -> writeData contains only the new words.
- Async reset mid-RECV after 2 words -> all outputs 0 immediately, without waiting for a clock edge. After release, a fresh 4-word load writes the correct data with no residue from the first 2 words.
- Start while busy and clamp: a second start during RECV is ignored (write count unchanged). numInstr=1025 -> exactly 1024 writes, then done.
